comparator: RTL and testbench
=============================

// Module: comparator
// PURPOSE
//   Registered magnitude comparator for two WIDTH-bit operands a and b.
//   Produces one-hot flags g (a>b), l (a<b), e (a==b) one clock after a valid sample.
//   Used as a leaf block in datapath/ALU compare paths and in lab exercises.
//   Unsigned by default; signed two's-complement compare is a compile-time option.
// PARAMETERS
//   WIDTH  4  operand width in bits (legal range 1..64)
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst        in   1      reset, synchronous, active-high
//   in_valid   in   1      a/b sampled this cycle when high
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   out_valid  out  1      g/l/e updated with new result this cycle
//   g          out  1      a greater than b
//   l          out  1      a less than b
//   e          out  1      a equal to b
// BEHAVIOUR
//   - All outputs registered; no combinational path from inputs to outputs.
//   - Reset (rst=1 at posedge): g=0, l=0, e=0, out_valid=0. rst overrides in_valid.
//   - Latency 1 cycle: in_valid=1 at edge N -> flags valid after edge N, out_valid=1.
//   - in_valid=0: out_valid=0 next cycle; g/l/e hold their last result (no clearing).
//   - Back-to-back in_valid every cycle allowed; throughput 1 compare/cycle, no stall.
//   - After the first valid compare, exactly one of g/l/e is high (one-hot invariant).
//   - Before any valid compare since reset, g=l=e=0.
//   - Compare is full-width; no truncation; no X-propagation tolerance needed.
//   - Equality independent of signedness; only ordering (g/l) depends on mode.
//   - Boundaries: a=b=0 -> e; a=all-ones,b=0 -> g (unsigned); WIDTH=1 works.
//   - rst asserted mid-stream: next cycle outputs at reset values; result discarded.
// CONFIGURATION
//   CMP_SIGNED_EN  defined: a and b treated as two's-complement signed values.
//                  e.g. WIDTH=4, a=4'b0011 (+3), b=4'b1011 (-5) -> g=1.
//   not defined:   a and b unsigned; same inputs -> l=1 (3 < 11).
//   Macro affects only g/l ordering; ports, latency and reset unchanged.
// TESTING
//   1. rst=1 two cycles -> g=l=e=0, out_valid=0; then rst=0, in_valid=0 -> unchanged.
//   2. Unsigned, valid stream a/b: 1011/1011 -> e; 1010/1011 -> l; 1011/1111 -> l;
//      0000/0000 -> e; 0011/1011 -> l; each result one cycle later, out_valid=1.
//   3. a=4'b1111, b=4'b0001 valid -> g=1,l=0,e=0; drop in_valid -> out_valid=0, g holds 1.
//   4. CMP_SIGNED_EN: 0011/1011 -> g; 1000/0111 -> l; 1111/1111 -> e.
//   5. rst=1 in same cycle as in_valid=1 (a=1111,b=0000) -> outputs stay reset values.
//   6. Random 1000 valid vectors vs model: one-hot holds; out_valid tracks in_valid delayed 1.

Source files
------------

// File: rtl/comparator.sv
// Registered magnitude comparator: one-hot g/l/e flags one cycle after a valid a/b sample.
// Define CMP_SIGNED_EN to order operands as two's-complement; the default build orders them unsigned.
module comparator #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic             g,
    output logic             l,
    output logic             e
);

    logic out_valid_q, out_valid_d;
    logic g_q, g_d;
    logic l_q, l_d;
    logic e_q, e_d;
    logic a_gt_b, a_lt_b, a_eq_b;

    // Equality never depends on signedness, so only the ordering is mode-specific.
    assign a_eq_b = (a == b);
`ifdef CMP_SIGNED_EN
    assign a_gt_b = ($signed(a) > $signed(b));
    assign a_lt_b = ($signed(a) < $signed(b));
`else
    assign a_gt_b = (a > b);
    assign a_lt_b = (a < b);
`endif

    // Flags hold their last result when no new sample arrives.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        out_valid_d = in_valid;
        g_d         = g_q;
        l_d         = l_q;
        e_d         = e_q;
        if (in_valid) begin
            g_d = a_gt_b;
            l_d = a_lt_b;
            e_d = a_eq_b;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            out_valid_q <= 1'b0;
            g_q         <= 1'b0;
            l_q         <= 1'b0;
            e_q         <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            g_q         <= g_d;
            l_q         <= l_d;
            e_q         <= e_d;
        end
    end

    assign out_valid = out_valid_q;
    assign g         = g_q;
    assign l         = l_q;
    assign e         = e_q;

endmodule

// File: tb/tb_comparator.sv
// Directed and random checks of comparator (WIDTH=4 and WIDTH=1); honours CMP_SIGNED_EN.
module tb_comparator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] a, b;
    logic       out_valid, g, l, e;
    logic       in_valid1;
    logic [0:0] a1, b1;
    logic       out_valid1, g1, l1, e1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    comparator #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(out_valid), .g(g), .l(l), .e(e)
    );

    comparator #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .a(a1), .b(b1),
        .out_valid(out_valid1), .g(g1), .l(l1), .e(e1)
    );

    // Reference ordering: {g, l, e}.
    function automatic logic [2:0] model(input logic [3:0] x, input logic [3:0] y);
`ifdef CMP_SIGNED_EN
        return {$signed(x) > $signed(y), $signed(x) < $signed(y), x == y};
`else
        return {x > y, x < y, x == y};
`endif
    endfunction

    task automatic step(input logic r, input logic v, input logic [3:0] x, input logic [3:0] y);
        @(negedge clk);
        rst = r; in_valid = v; a = x; b = y;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        exp = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 4'h0, 4'h0);
            checks++;
            if ({out_valid, g, l, e} !== exp) begin
                errors++;
                $display("FAIL reset_%0d: got v,g,l,e=%b want %b", i, {out_valid, g, l, e}, exp);
            end
        end
        step(1'b0, 1'b0, 4'h0, 4'h0);
        checks++;
        if ({out_valid, g, l, e} !== exp) begin
            errors++;
            $display("FAIL reset_idle: got v,g,l,e=%b want %b", {out_valid, g, l, e}, exp);
        end
    endtask

    task automatic test_stream();
        logic [3:0] va [5] = '{4'b1011, 4'b1010, 4'b1011, 4'b0000, 4'b0011};
        logic [3:0] vb [5] = '{4'b1011, 4'b1011, 4'b1111, 4'b0000, 4'b1011};
`ifdef CMP_SIGNED_EN
        logic [3:0] ve [5] = '{4'b1001, 4'b1010, 4'b1010, 4'b1001, 4'b1100};
`else
        logic [3:0] ve [5] = '{4'b1001, 4'b1010, 4'b1010, 4'b1001, 4'b1010};
`endif
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, va[i], vb[i]);
            checks++;
            if ({out_valid, g, l, e} !== ve[i]) begin
                errors++;
                $display("FAIL stream_%0d a=%b b=%b: got v,g,l,e=%b want %b",
                         i, va[i], vb[i], {out_valid, g, l, e}, ve[i]);
            end
        end
    endtask

    task automatic test_hold();
`ifdef CMP_SIGNED_EN
        logic [3:0] exp = 4'b1010;
`else
        logic [3:0] exp = 4'b1100;
`endif
        step(1'b0, 1'b1, 4'b1111, 4'b0001);
        checks++;
        if ({out_valid, g, l, e} !== exp) begin
            errors++;
            $display("FAIL hold_result: got v,g,l,e=%b want %b", {out_valid, g, l, e}, exp);
        end
        exp[3] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 4'b0000, 4'b0000);
            checks++;
            if ({out_valid, g, l, e} !== exp) begin
                errors++;
                $display("FAIL hold_idle_%0d: got v,g,l,e=%b want %b", i, {out_valid, g, l, e}, exp);
            end
        end
    endtask

    task automatic test_signed_order();
        logic [3:0] va [3] = '{4'b0011, 4'b1000, 4'b1111};
        logic [3:0] vb [3] = '{4'b1011, 4'b0111, 4'b1111};
`ifdef CMP_SIGNED_EN
        logic [3:0] ve [3] = '{4'b1100, 4'b1010, 4'b1001};
`else
        logic [3:0] ve [3] = '{4'b1010, 4'b1100, 4'b1001};
`endif
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, va[i], vb[i]);
            checks++;
            if ({out_valid, g, l, e} !== ve[i]) begin
                errors++;
                $display("FAIL order_%0d a=%b b=%b: got v,g,l,e=%b want %b",
                         i, va[i], vb[i], {out_valid, g, l, e}, ve[i]);
            end
        end
    endtask

    task automatic test_reset_override();
        step(1'b0, 1'b1, 4'b0101, 4'b0101);
        checks++;
        if ({out_valid, g, l, e} !== 4'b1001) begin
            errors++;
            $display("FAIL rst_pre: got v,g,l,e=%b want 1001", {out_valid, g, l, e});
        end
        step(1'b1, 1'b1, 4'b1111, 4'b0000);
        checks++;
        if ({out_valid, g, l, e} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_override: got v,g,l,e=%b want 0000", {out_valid, g, l, e});
        end
        step(1'b0, 1'b0, 4'b1111, 4'b0000);
        checks++;
        if ({out_valid, g, l, e} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_discard: got v,g,l,e=%b want 0000", {out_valid, g, l, e});
        end
    endtask

    task automatic test_width1();
        logic [0:0] va [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [0:0] vb [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
`ifdef CMP_SIGNED_EN
        logic [3:0] ve [4] = '{4'b1010, 4'b1001, 4'b1100, 4'b1001};
`else
        logic [3:0] ve [4] = '{4'b1100, 4'b1001, 4'b1010, 4'b1001};
`endif
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rst = 1'b0; in_valid = 1'b0; in_valid1 = 1'b1; a1 = va[i]; b1 = vb[i];
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid1, g1, l1, e1} !== ve[i]) begin
                errors++;
                $display("FAIL width1_%0d a=%b b=%b: got v,g,l,e=%b want %b",
                         i, va[i], vb[i], {out_valid1, g1, l1, e1}, ve[i]);
            end
        end
        @(negedge clk);
        in_valid1 = 1'b0;
    endtask

    task automatic test_random();
        logic       v;
        logic [3:0] x, y;
        logic [2:0] held;
        logic [3:0] exp;
        // Reset first so the held-flags model starts from a known state.
        step(1'b1, 1'b0, 4'h0, 4'h0);
        held = 3'b000;
        for (int i = 0; i < 1000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            x = 4'($urandom);
            y = 4'($urandom);
            step(1'b0, v, x, y);
            if (v) held = model(x, y);
            exp = {v, held};
            checks++;
            if ({out_valid, g, l, e} !== exp) begin
                errors++;
                $display("FAIL rand_%0d v=%b a=%b b=%b: got v,g,l,e=%b want %b",
                         i, v, x, y, {out_valid, g, l, e}, exp);
            end
            if (held != 3'b000) begin
                checks++;
                if ($countones({g, l, e}) != 1) begin
                    errors++;
                    $display("FAIL rand_onehot_%0d: got g,l,e=%b want exactly one set", i, {g, l, e});
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
        in_valid1 = 1'b0; a1 = '0; b1 = '0;
        test_reset();
        test_stream();
        test_hold();
        test_signed_order();
        test_reset_override();
        test_width1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
